pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Supervises the PLL_INIT + PLL pair: drives the PLL_INIT reset input and watches its gated lock output.
- Qualifies lock over a stability window, times out and retries a failed bring-up, and releases downstream clock-domain resets in a staggered order.
- Re-runs the whole init sequence on runtime lock loss.
- Sits between the PLL bring-up logic and the system reset tree (e.g. the sensor/MIPI/video domains); clocked by the same free-running reference as PLL_INIT.

Parameters:
- RST_PULSE, 16: cycles O_INIT_RST is held high per init attempt (>=1).
- TIMEOUT_CYCLES, 200000: max cycles waiting for lock per attempt (10 ms @ 20 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release.
- MAX_RETRY, 3: retries allowed after the first attempt before FAIL (0..15).
- NUM_DOMAIN, 2: number of downstream reset outputs (1..8).
- STAGGER_CYCLES, 256: delay between successive domain reset releases (>=1).

Ports:
- CLKIN  in  1  reference clock, same clock as PLL_INIT.
- I_RST  in  1  asynchronous, active-high reset.
- I_LOCK  in  1  lock from PLL_INIT O_LOCK; async to CLKIN; synchronized internally.
- I_RETRY  in  1  one-cycle pulse; restarts from FAIL; ignored in other states.
- O_INIT_RST  out  1  reset to PLL_INIT I_RST.
- O_DOMAIN_RST  out  NUM_DOMAIN  active-high resets; bit 0 released first.
- O_READY  out  1  high only in RUN.
- O_FAIL  out  1  high only in FAIL.
- O_RETRY_CNT  out  4  retries consumed in the current bring-up.
- O_UNLOCK_CNT  out  8  runtime lock-loss events; saturates at 255.

Behaviour:
- Reset (I_RST high, async): state=INIT_RST; O_INIT_RST=1; O_DOMAIN_RST all 1; O_READY=0; O_FAIL=0; O_RETRY_CNT=0; O_UNLOCK_CNT=0; lock synchronizer=0; all counters=0. All outputs are registered.
- Lock sync: two-flop synchronizer; "lock" below means the synchronized value, which lags I_LOCK by 2 cycles.
- Single shared cycle counter `cnt`. It clears to 0 on every state entry.

States:
- INIT_RST
  - O_INIT_RST=1 and all domain resets=1.
  - After RST_PULSE cycles -> WAIT_LOCK.
- WAIT_LOCK
  - O_INIT_RST=0.
  - lock=1 -> STABLE.
  - cnt reaches TIMEOUT_CYCLES-1 with lock=0 -> retry decision.
- STABLE
  - Counts consecutive lock=1 cycles.
  - cnt reaches STABLE_CYCLES-1 -> RELEASE.
  - lock=0 in any cycle -> retry decision. No debounce back to WAIT_LOCK.
- Retry decision
  - If O_RETRY_CNT == MAX_RETRY -> FAIL.
  - Else increment O_RETRY_CNT -> INIT_RST.
- RELEASE
  - On the entry cycle, deassert O_DOMAIN_RST[0]. Deassert bit k at cnt == k*STAGGER_CYCLES.
  - After the last bit is deasserted -> RUN on the next cycle.
  - lock=0 while in RELEASE is treated as a runtime loss (see RUN).
- RUN
  - O_READY=1.
  - lock=0 -> in the same transition: all O_DOMAIN_RST=1, O_READY=0, O_UNLOCK_CNT+1 (saturating), O_RETRY_CNT=0 (fresh retry budget) -> INIT_RST.
- FAIL
  - O_FAIL=1; O_INIT_RST=1 (PLL held in reset); all domain resets=1.
  - I_RETRY -> O_RETRY_CNT=0, O_FAIL=0 -> INIT_RST.
  - O_UNLOCK_CNT is preserved.

Additional rules:
- O_RETRY_CNT holds its value in RUN for diagnostics.
- Domain resets are never deasserted outside RELEASE/RUN. A deasserted bit stays deasserted until lock loss, FAIL or I_RST.
- Simultaneous lock drop and stage boundary in STABLE/RELEASE: lock loss wins.
- I_RETRY outside FAIL has no effect.
- Mid-operation I_RST: immediate return to the reset values in any state.
- Counter width: $clog2 of the largest of RST_PULSE, TIMEOUT_CYCLES, STABLE_CYCLES and (NUM_DOMAIN-1)*STAGGER_CYCLES+1. No wrap is possible before the terminal compare.

Test Plan (bench overrides: RST_PULSE=4, TIMEOUT_CYCLES=100, STABLE_CYCLES=20, MAX_RETRY=2, NUM_DOMAIN=3, STAGGER_CYCLES=8):
1. Clean bring-up: I_LOCK rises 30 cycles after reset release and stays high -> O_INIT_RST low 4 cycles after reset; STABLE entered 2 cycles after the rise; domain resets drop at RELEASE+0/+8/+16; O_READY=1 and O_RETRY_CNT=0.
2. Lock never asserts -> 3 INIT_RST pulses of 4 cycles, 100 cycles apart (plus the pulse); then O_FAIL=1 and O_RETRY_CNT=2. A later I_RETRY pulse -> O_FAIL=0, new INIT_RST, O_RETRY_CNT=0.
3. Lock glitch: I_LOCK high 10 cycles, low 1 cycle, then high -> retry (O_RETRY_CNT=1, new INIT_RST); second attempt succeeds to RUN; O_RETRY_CNT stays 1.
4. Runtime loss: in RUN, drop I_LOCK for 3 cycles -> within 3 cycles all O_DOMAIN_RST=1, O_READY=0, O_UNLOCK_CNT=1, O_RETRY_CNT=0; after lock returns, full re-release to RUN.
5. Loss during RELEASE after bit 0 is deasserted -> bit 0 reasserts, O_UNLOCK_CNT increments, bits 1-2 never deassert.
6. Async I_RST pulsed mid-RUN (not clock-aligned) -> all outputs return to reset values the same instant; O_UNLOCK_CNT=0. Also force 256 runtime losses -> O_UNLOCK_CNT saturates at 255.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Brings up a PLL through its PLL_INIT wrapper and owns the downstream
// clock-domain resets. Each attempt pulses the PLL_INIT reset, waits for
// lock, and then qualifies lock over a stability window. A failed attempt
// is retried until the retry budget runs out, and the block then parks in
// FAIL. After lock qualifies, the domain resets are released one at a time
// with a fixed stagger. Losing lock after release re-runs the whole
// sequence.
//
// Ports
//   CLKIN         free-running reference clock (same as PLL_INIT)
//   I_RST         asynchronous active-high reset
//   I_LOCK        PLL_INIT lock, asynchronous, synchronized here
//   I_RETRY       one-cycle pulse, leaves FAIL, ignored elsewhere
//   O_INIT_RST    reset to PLL_INIT
//   O_DOMAIN_RST  active-high domain resets, bit 0 released first
//   O_READY       high in RUN
//   O_FAIL        high in FAIL
//   O_RETRY_CNT   retries consumed in the current bring-up
//   O_UNLOCK_CNT  runtime lock-loss events, saturating at 255
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT_RST  | PLL_INIT held in reset for RST_PULSE cycles
// WAIT_LOCK | reset released, waiting up to TIMEOUT_CYCLES for lock
// STABLE    | lock seen, must stay high for STABLE_CYCLES
// RELEASE   | domain resets released, one every STAGGER_CYCLES
// RUN       | all domains out of reset, watching for lock loss
// FAIL      | retry budget exhausted, PLL held in reset until I_RETRY

module pll_lock_supervisor #(
    parameter int RST_PULSE      = 16,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int NUM_DOMAIN     = 2,
    parameter int STAGGER_CYCLES = 256
) (
    input  logic                  CLKIN,
    input  logic                  I_RST,
    input  logic                  I_LOCK,
    input  logic                  I_RETRY,
    output logic                  O_INIT_RST,
    output logic [NUM_DOMAIN-1:0] O_DOMAIN_RST,
    output logic                  O_READY,
    output logic                  O_FAIL,
    output logic [3:0]            O_RETRY_CNT,
    output logic [7:0]            O_UNLOCK_CNT
);

    localparam int REL_LAST = (NUM_DOMAIN - 1) * STAGGER_CYCLES;
    localparam int MAX_A    = (RST_PULSE > TIMEOUT_CYCLES) ? RST_PULSE : TIMEOUT_CYCLES;
    localparam int MAX_B    = (STABLE_CYCLES > REL_LAST + 1) ? STABLE_CYCLES : REL_LAST + 1;
    localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_END      = CNT_W'(REL_LAST);
    localparam logic [3:0]       RETRY_LIM    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_INIT_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             sync_q, sync_d;
    logic                   init_rst_q, init_rst_d;
    logic [NUM_DOMAIN-1:0]  domain_rst_q, domain_rst_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;
    logic [3:0]             retry_q, retry_d;
    logic [7:0]             unlock_q, unlock_d;
    logic                   lock;
    logic                   take_retry;
    logic                   take_loss;

    assign lock = sync_q[1];

    always_ff @(posedge CLKIN or posedge I_RST) begin
        if (I_RST) begin
            state_q      <= ST_INIT_RST;
            cnt_q        <= '0;
            sync_q       <= '0;
            init_rst_q   <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            retry_q      <= '0;
            unlock_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            init_rst_q   <= init_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
            retry_q      <= retry_d;
            unlock_q     <= unlock_d;
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        retry_d    = retry_q;
        unlock_d   = unlock_q;
        sync_d     = {sync_q[0], I_LOCK};
        take_retry = 1'b0;
        take_loss  = 1'b0;

        // Lock checks come before terminal-count compares so that a lock
        // drop coinciding with a stage boundary is always treated as loss.
        case (state_q)
            ST_INIT_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock)                        state_d    = ST_STABLE;
                else if (cnt_q == TIMEOUT_LAST)  take_retry = 1'b1;
            end
            ST_STABLE: begin
                if (!lock)                       take_retry = 1'b1;
                else if (cnt_q == STABLE_LAST)   state_d    = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!lock)                       take_loss  = 1'b1;
                else if (cnt_q == REL_END)       state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (!lock)                       take_loss  = 1'b1;
            end
            ST_FAIL: begin
                if (I_RETRY) begin
                    retry_d = '0;
                    state_d = ST_INIT_RST;
                end
            end
            default: state_d = ST_INIT_RST;
        endcase

        if (take_retry) begin
            if (retry_q == RETRY_LIM) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = ST_INIT_RST;
            end
        end

        // A runtime loss starts a fresh bring-up with a full retry budget.
        if (take_loss) begin
            retry_d  = '0;
            unlock_d = (unlock_q != 8'hFF) ? unlock_q + 8'd1 : unlock_q;
            state_d  = ST_INIT_RST;
        end

        // RUN and FAIL have no terminal count, so the counter is frozen there.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == ST_RUN || state_q == ST_FAIL)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Output flops are loaded from the next state so every output lines up
    // with the state it belongs to.
    always_comb begin : outputs
        init_rst_d   = (state_d == ST_INIT_RST) || (state_d == ST_FAIL);
        ready_d      = (state_d == ST_RUN);
        fail_d       = (state_d == ST_FAIL);
        domain_rst_d = '1;
        if (state_d == ST_RELEASE || state_d == ST_RUN) begin
            domain_rst_d = domain_rst_q;
            if (state_d == ST_RELEASE) begin
                for (int k = 0; k < NUM_DOMAIN; k++) begin
                    if (cnt_d == CNT_W'(k * STAGGER_CYCLES)) domain_rst_d[k] = 1'b0;
                end
            end
        end
    end

    assign O_INIT_RST   = init_rst_q;
    assign O_DOMAIN_RST = domain_rst_q;
    assign O_READY      = ready_q;
    assign O_FAIL       = fail_q;
    assign O_RETRY_CNT  = retry_q;
    assign O_UNLOCK_CNT = unlock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 100;
    localparam int SC = 20;
    localparam int MR = 2;
    localparam int ND = 3;
    localparam int SG = 8;
    localparam int REL_LAST = (ND - 1) * SG;

    logic          clk = 1'b0;
    logic          rst;
    logic          lock;
    logic          retry;
    logic          o_init_rst;
    logic [ND-1:0] o_domain_rst;
    logic          o_ready;
    logic          o_fail;
    logic [3:0]    o_retry_cnt;
    logic [7:0]    o_unlock_cnt;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RST_PULSE      (RP),
        .TIMEOUT_CYCLES (TO),
        .STABLE_CYCLES  (SC),
        .MAX_RETRY      (MR),
        .NUM_DOMAIN     (ND),
        .STAGGER_CYCLES (SG)
    ) dut (
        .CLKIN        (clk),
        .I_RST        (rst),
        .I_LOCK       (lock),
        .I_RETRY      (retry),
        .O_INIT_RST   (o_init_rst),
        .O_DOMAIN_RST (o_domain_rst),
        .O_READY      (o_ready),
        .O_FAIL       (o_fail),
        .O_RETRY_CNT  (o_retry_cnt),
        .O_UNLOCK_CNT (o_unlock_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a bring-up is described by the cycle its reset pulse
    // began (m_a_start) and the cycle lock qualification began (m_q_start,
    // -1 while still waiting). Outputs follow from elapsed time alone.
    int m_n;
    int m_a_start;
    int m_q_start;
    bit m_failed;
    int m_retries;
    int m_unlocks;
    bit m_lh1, m_lh2;

    function automatic logic [17:0] mk(logic i, logic [2:0] d, logic r, logic f,
                                       logic [3:0] rc, logic [7:0] uc);
        return {i, d, r, f, rc, uc};
    endfunction

    localparam logic [17:0] RST_VAL = {1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0};

    function automatic logic [17:0] dut_pack();
        return {o_init_rst, o_domain_rst, o_ready, o_fail, o_retry_cnt, o_unlock_cnt};
    endfunction

    task automatic model_reset();
        m_n = 0; m_a_start = 0; m_q_start = -1; m_failed = 0;
        m_retries = 0; m_unlocks = 0; m_lh1 = 0; m_lh2 = 0;
    endtask

    task automatic new_attempt();
        m_a_start = m_n;
        m_q_start = -1;
    endtask

    task automatic model_step(input logic in_lock, input logic in_retry);
        bit lk;
        int m;
        m_n++;
        lk = m_lh2;
        m_lh2 = m_lh1;
        m_lh1 = in_lock;
        m = m_n - 1;
        if (m_failed) begin
            if (in_retry) begin
                m_failed = 0;
                m_retries = 0;
                new_attempt();
            end
        end else if (m_q_start < 0) begin
            if (m - m_a_start >= RP) begin
                if (lk) m_q_start = m_n;
                else if (m - m_a_start - RP == TO - 1) begin
                    if (m_retries == MR) m_failed = 1;
                    else begin m_retries++; new_attempt(); end
                end
            end
        end else if (!lk) begin
            if (m - m_q_start < SC) begin
                if (m_retries == MR) m_failed = 1;
                else begin m_retries++; new_attempt(); end
            end else begin
                if (m_unlocks < 255) m_unlocks++;
                m_retries = 0;
                new_attempt();
            end
        end
    endtask

    function automatic logic [17:0] model_pack();
        logic       i, r, f;
        logic [2:0] d;
        int         rel;
        i = 0; r = 0; f = 0; d = 3'b111;
        if (m_failed) begin
            i = 1; f = 1;
        end else if (m_q_start < 0) begin
            i = (m_n - m_a_start) < RP;
        end else begin
            rel = m_n - m_q_start - SC;
            for (int k = 0; k < ND; k++) d[k] = !(rel >= k * SG);
            r = rel > REL_LAST;
        end
        return mk(i, d, r, f, 4'(m_retries), 8'(m_unlocks));
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got init=%b dom=%b rdy=%b fail=%b rc=%0d uc=%0d, want init=%b dom=%b rdy=%b fail=%b rc=%0d uc=%0d",
                     name, m_n, act[17], act[16:14], act[13], act[12], act[11:8], act[7:0],
                     exp[17], exp[16:14], exp[13], exp[12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic tick();
        logic cl, cr;
        cl = lock;
        cr = retry;
        @(posedge clk);
        model_step(cl, cr);
        @(negedge clk);
        check("model", dut_pack(), model_pack());
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_async", dut_pack(), RST_VAL);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       lk;
        int         ncyc;
        logic       e_init;
        logic [2:0] e_dom;
        logic       e_ready;
        logic       e_fail;
        logic [3:0] e_rc;
        logic [7:0] e_uc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Clean bring-up then a 3-cycle runtime loss and re-release.
        vecs[0]  = '{1'b0,  3, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[1]  = '{1'b0,  1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[2]  = '{1'b0, 26, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[3]  = '{1'b1, 22, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[4]  = '{1'b1,  1, 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[5]  = '{1'b1,  7, 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[6]  = '{1'b1,  1, 1'b0, 3'b100, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[7]  = '{1'b1,  8, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0};
        vecs[8]  = '{1'b1,  1, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd0};
        vecs[9]  = '{1'b0,  3, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1};
        vecs[10] = '{1'b1,  4, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1};
        vecs[11] = '{1'b1, 21, 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 8'd1};
        vecs[12] = '{1'b1, 17, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd1};

        rst = 1'b1; lock = 1'b0; retry = 1'b0;
        model_reset();
        #1;
        check("reset_at_start", dut_pack(), RST_VAL);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", dut_pack(), RST_VAL);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            lock = vecs[i].lk;
            ticks(vecs[i].ncyc);
            check($sformatf("vec%0d", i), dut_pack(),
                  mk(vecs[i].e_init, vecs[i].e_dom, vecs[i].e_ready, vecs[i].e_fail,
                     vecs[i].e_rc, vecs[i].e_uc));
        end

        // Lock never arrives: two retries, then FAIL, then I_RETRY.
        do_reset();
        lock = 1'b0;
        ticks(104);
        check("t2_retry1_pulse", dut_pack(), mk(1, 3'b111, 0, 0, 4'd1, 8'd0));
        ticks(4);
        check("t2_pulse_end", dut_pack(), mk(0, 3'b111, 0, 0, 4'd1, 8'd0));
        ticks(42);
        retry = 1'b1; tick(); retry = 1'b0;
        check("t2_retry_ignored", dut_pack(), mk(0, 3'b111, 0, 0, 4'd1, 8'd0));
        ticks(160);
        check("t2_before_fail", dut_pack(), mk(0, 3'b111, 0, 0, 4'd2, 8'd0));
        tick();
        check("t2_fail", dut_pack(), mk(1, 3'b111, 0, 1, 4'd2, 8'd0));
        ticks(5);
        check("t2_fail_hold", dut_pack(), mk(1, 3'b111, 0, 1, 4'd2, 8'd0));
        retry = 1'b1; tick(); retry = 1'b0;
        check("t2_restart", dut_pack(), mk(1, 3'b111, 0, 0, 4'd0, 8'd0));
        ticks(4);
        check("t2_restart_wait", dut_pack(), mk(0, 3'b111, 0, 0, 4'd0, 8'd0));

        // One-cycle lock glitch during qualification.
        do_reset();
        lock = 1'b1; ticks(10);
        lock = 1'b0; tick();
        lock = 1'b1; tick();
        check("t3_pre_glitch", dut_pack(), mk(0, 3'b111, 0, 0, 4'd0, 8'd0));
        tick();
        check("t3_glitch_retry", dut_pack(), mk(1, 3'b111, 0, 0, 4'd1, 8'd0));
        ticks(41);
        check("t3_release_last", dut_pack(), mk(0, 3'b000, 0, 0, 4'd1, 8'd0));
        tick();
        check("t3_run", dut_pack(), mk(0, 3'b000, 1, 0, 4'd1, 8'd0));

        // Lock lost during RELEASE after bit 0 has been released.
        do_reset();
        lock = 1'b1; ticks(27);
        check("t5_bit0_released", dut_pack(), mk(0, 3'b110, 0, 0, 4'd0, 8'd0));
        lock = 1'b0; ticks(2);
        check("t5_sync_lag", dut_pack(), mk(0, 3'b110, 0, 0, 4'd0, 8'd0));
        tick();
        check("t5_loss", dut_pack(), mk(1, 3'b111, 0, 0, 4'd0, 8'd1));
        ticks(20);
        check("t5_held", dut_pack(), mk(0, 3'b111, 0, 0, 4'd0, 8'd1));
        lock = 1'b1; ticks(60);
        check("t5_recovered", dut_pack(), mk(0, 3'b000, 1, 0, 4'd0, 8'd1));

        // 256 runtime losses saturate the counter; async reset clears it.
        do_reset();
        lock = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ticks(50);
            lock = 1'b0; tick(); lock = 1'b1;
        end
        ticks(3);
        check("t6_saturated", dut_pack(), mk(1, 3'b111, 0, 0, 4'd0, 8'd255));
        ticks(60);
        check("t6_run", dut_pack(), mk(0, 3'b000, 1, 0, 4'd0, 8'd255));
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_reset", dut_pack(), RST_VAL);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized lock behaviour and stray retry pulses against the model.
        begin
            int total;
            int len;
            total = 0;
            lock = 1'b0;
            while (total < 4000) begin
                lock = ~lock;
                if (lock) len = $urandom_range(1, 80);
                else if ($urandom_range(0, 7) == 0) len = $urandom_range(300, 360);
                else len = $urandom_range(1, 30);
                repeat (len) begin
                    retry = ($urandom_range(0, 15) == 0);
                    tick();
                end
                retry = 1'b0;
                total += len;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
